// File: rtl/sb_pkg.sv
// ---------------------------------------------------------------------------
// sb_pkg
// Shared types and default sizing for the ALU issue scoreboard.
//   sb_state_t : life cycle of one architectural register with a pending write
//   bp_sel_t   : ALU operand source select (register file, ALU bypass, cache bypass)
// ---------------------------------------------------------------------------
package sb_pkg;

    // FREE : no write outstanding, RF holds the architectural value
    // EXEC : ALU/MUL result still being computed, cnt counts the cycles left
    // BP   : result sits on the ALU bypass for exactly one unstalled cycle
    // MEM  : load issued, waiting for the D$ to return data
    // WAIT : result has left the bypass network, waiting for WB to write the RF
    typedef enum logic [2:0] {
        FREE = 3'd0,
        EXEC = 3'd1,
        BP   = 3'd2,
        MEM  = 3'd3,
        WAIT = 3'd4
    } sb_state_t;

    typedef enum logic [1:0] {
        BP_RF    = 2'b00,
        BP_ALU   = 2'b01,
        BP_CACHE = 2'b10
    } bp_sel_t;

    localparam int SB_NUM_REGS    = 32;
    localparam int SB_ADDR_W      = 5;
    localparam int SB_MUL_LATENCY = 5;
    localparam int SB_CNT_W       = 3;

    // Latency loaded into an entry when a non-load instruction issues.
    function automatic logic [SB_CNT_W-1:0] exec_latency(input logic is_mul);
        logic [SB_CNT_W-1:0] lat;
        if (is_mul) begin
            lat = SB_CNT_W'(SB_MUL_LATENCY);
        end else begin
            lat = SB_CNT_W'(1);
        end
        return lat;
    endfunction

endpackage

// File: rtl/sb_entry.sv
// ---------------------------------------------------------------------------
// sb_entry
// Tracks the pending-write state of one architectural register and reports
// whether a reader of that register can be served this cycle, and from where.
// Ports:
//   clock, reset    : clock, asynchronous active-low reset
//   issue_wr        : an instruction writing this register issues this cycle
//   issue_is_mul    : that instruction is a MUL (long EXEC latency)
//   issue_is_load   : that instruction is a load (wait for the D$)
//   stall_alu       : downstream stall, freezes EXEC countdown and BP window
//   mem_hit         : D$ returns data for this register this cycle
//   wb_hit          : WB writes this register this cycle
//   state           : registered entry state
//   ready           : a reader of this register may issue this cycle
//   bp_sel          : operand source for that reader
// ---------------------------------------------------------------------------
module sb_entry
    import sb_pkg::*;
#(
    parameter int CNT_W = SB_CNT_W
) (
    input  logic      clock,
    input  logic      reset,
    input  logic      issue_wr,
    input  logic      issue_is_mul,
    input  logic      issue_is_load,
    input  logic      stall_alu,
    input  logic      mem_hit,
    input  logic      wb_hit,
    output sb_state_t state,
    output logic      ready,
    output bp_sel_t   bp_sel
);

    sb_state_t          state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [SB_CNT_W-1:0] lat_s;

    assign lat_s = exec_latency(issue_is_mul);
    assign state = state_r;

    // Entry state machine: a new issue overrides everything, then a WB clear,
    // then the normal progression through the pipeline.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= FREE;
            cnt_r   <= {CNT_W{1'b0}};
        end else if (issue_wr) begin
            if (issue_is_load) begin
                state_r <= MEM;
                cnt_r   <= {CNT_W{1'b0}};
            end else begin
                state_r <= EXEC;
                cnt_r   <= CNT_W'(lat_s);
            end
        end else if (wb_hit && (state_r != FREE)) begin
            state_r <= FREE;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                EXEC: begin
                    if (!stall_alu) begin
                        // <= also catches a zero count, so the entry can never wrap
                        if (cnt_r <= CNT_W'(1)) begin
                            state_r <= BP;
                            cnt_r   <= {CNT_W{1'b0}};
                        end else begin
                            cnt_r <= cnt_r - CNT_W'(1);
                        end
                    end
                end
                BP: begin
                    if (!stall_alu) begin
                        state_r <= WAIT;
                    end
                end
                MEM: begin
                    if (mem_hit) begin
                        state_r <= WAIT;
                    end
                end
                WAIT: begin
                    state_r <= WAIT;
                end
                FREE: begin
                    state_r <= FREE;
                end
                default: begin
                    state_r <= FREE;
                    cnt_r   <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // Reader readiness: a WB this cycle writes through the RF, so it is
    // preferred over any bypass path.
    always_comb begin
        ready  = 1'b0;
        bp_sel = BP_RF;
        if (state_r == FREE) begin
            ready  = 1'b1;
            bp_sel = BP_RF;
        end else if (wb_hit) begin
            ready  = 1'b1;
            bp_sel = BP_RF;
        end else if (state_r == BP) begin
            ready  = 1'b1;
            bp_sel = BP_ALU;
        end else if ((state_r == MEM) && mem_hit) begin
            ready  = 1'b1;
            bp_sel = BP_CACHE;
        end else begin
            ready  = 1'b0;
            bp_sel = BP_RF;
        end
    end

endmodule

// File: rtl/alu_issue_scoreboard.sv
// ---------------------------------------------------------------------------
// alu_issue_scoreboard
// Issue controller between decode and alu_top. Keeps one sb_entry per
// architectural register (r0 is hardwired zero and untracked), resolves
// RAW/WAW hazards for the decoded instruction and drives the operand bypass
// selects.
// Ports:
//   clock, reset                : clock, asynchronous active-low reset
//   dec_*                       : decoded instruction fields and flags
//   stall_alu                   : downstream stall
//   flush                       : taken branch, kill the decode instruction
//   mem_done_valid/mem_done_rd  : D$ load return
//   wb_valid/wb_rd              : register file write
//   issue_valid                 : instruction accepted by the ALU
//   dec_stall                   : hold decode/fetch
//   ra_bp_sel/rb_bp_sel         : 00 RF, 01 ALU bypass, 10 cache bypass
//   sb_pending                  : bit i set when register i is not FREE
// ---------------------------------------------------------------------------
module alu_issue_scoreboard
    import sb_pkg::*;
#(
    parameter int NUM_REGS    = SB_NUM_REGS,
    parameter int ADDR_W      = SB_ADDR_W,
    parameter int MUL_LATENCY = SB_MUL_LATENCY,
    parameter int CNT_W       = SB_CNT_W
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                dec_valid,
    input  logic [ADDR_W-1:0]   dec_ra_addr,
    input  logic [ADDR_W-1:0]   dec_rb_addr,
    input  logic [ADDR_W-1:0]   dec_rd_addr,
    input  logic                dec_uses_ra,
    input  logic                dec_uses_rb,
    input  logic                dec_writes_rd,
    input  logic                dec_is_mul,
    input  logic                dec_is_load,
    input  logic                stall_alu,
    input  logic                flush,
    input  logic                mem_done_valid,
    input  logic [ADDR_W-1:0]   mem_done_rd,
    input  logic                wb_valid,
    input  logic [ADDR_W-1:0]   wb_rd,
    output logic                issue_valid,
    output logic                dec_stall,
    output logic [1:0]          ra_bp_sel,
    output logic [1:0]          rb_bp_sel,
    output logic [NUM_REGS-1:0] sb_pending
);

    localparam logic [ADDR_W-1:0] R0 = {ADDR_W{1'b0}};

    logic [NUM_REGS-1:0][2:0] ent_state_s;
    logic [NUM_REGS-1:0][1:0] ent_sel_s;
    logic [NUM_REGS-1:0]      ent_ready_s;
    logic [NUM_REGS-1:0]      mem_hit_s;
    logic [NUM_REGS-1:0]      wb_hit_s;
    logic [NUM_REGS-1:0]      issue_wr_s;

    logic src_a_live_s;
    logic src_b_live_s;
    logic ready_a_s;
    logic ready_b_s;
    logic rd_busy_s;
    logic hazard_s;

    // Address decode of the completion buses; r0 never matches.
    always_comb begin
        mem_hit_s = {NUM_REGS{1'b0}};
        wb_hit_s  = {NUM_REGS{1'b0}};
        for (int i = 1; i < NUM_REGS; i++) begin
            mem_hit_s[i] = mem_done_valid && (mem_done_rd == ADDR_W'(i));
            wb_hit_s[i]  = wb_valid && (wb_rd == ADDR_W'(i));
        end
    end

    // Destination decode of the issuing instruction; writes to r0 are dropped.
    always_comb begin
        issue_wr_s = {NUM_REGS{1'b0}};
        for (int i = 1; i < NUM_REGS; i++) begin
            issue_wr_s[i] = issue_valid && dec_writes_rd && (dec_rd_addr == ADDR_W'(i));
        end
    end

    // r0 behaves as a permanently FREE entry so the muxes need no special case.
    assign ent_state_s[0] = FREE;
    assign ent_ready_s[0] = 1'b1;
    assign ent_sel_s[0]   = BP_RF;

    for (genvar g = 1; g < NUM_REGS; g++) begin : g_entry
        sb_entry #(
            .CNT_W (CNT_W)
        ) u_entry (
            .clock         (clock),
            .reset         (reset),
            .issue_wr      (issue_wr_s[g]),
            .issue_is_mul  (dec_is_mul),
            .issue_is_load (dec_is_load),
            .stall_alu     (stall_alu),
            .mem_hit       (mem_hit_s[g]),
            .wb_hit        (wb_hit_s[g]),
            .state         (ent_state_s[g]),
            .ready         (ent_ready_s[g]),
            .bp_sel        (ent_sel_s[g])
        );
    end

    // Source readiness and bypass selects; unused sources and r0 read the RF.
    always_comb begin
        src_a_live_s = dec_uses_ra && (dec_ra_addr != R0);
        src_b_live_s = dec_uses_rb && (dec_rb_addr != R0);
        if (src_a_live_s) begin
            ready_a_s = ent_ready_s[dec_ra_addr];
            ra_bp_sel = ent_sel_s[dec_ra_addr];
        end else begin
            ready_a_s = 1'b1;
            ra_bp_sel = BP_RF;
        end
        if (src_b_live_s) begin
            ready_b_s = ent_ready_s[dec_rb_addr];
            rb_bp_sel = ent_sel_s[dec_rb_addr];
        end else begin
            ready_b_s = 1'b1;
            rb_bp_sel = BP_RF;
        end
    end

    // Hazard and issue decision. A WB to rd this cycle releases the WAW hazard
    // because the new issue state overrides the clear in the entry.
    always_comb begin
        rd_busy_s   = dec_writes_rd && (dec_rd_addr != R0)
                      && (ent_state_s[dec_rd_addr] != FREE)
                      && !wb_hit_s[dec_rd_addr];
        hazard_s    = !ready_a_s || !ready_b_s || rd_busy_s;
        issue_valid = dec_valid && !hazard_s && !stall_alu && !flush;
        dec_stall   = dec_valid && !flush && (hazard_s || stall_alu);
    end

    // Debug/perf view of the registered entry states.
    always_comb begin
        sb_pending = {NUM_REGS{1'b0}};
        for (int i = 0; i < NUM_REGS; i++) begin
            sb_pending[i] = (ent_state_s[i] != FREE);
        end
    end

endmodule

// File: tb/tb_alu_issue_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_scoreboard
// Directed scenarios plus a randomized run checked against a behavioural
// model that tracks, per register, whether a write is outstanding, whether it
// is a load, how many execute cycles remain and whether the result has
// already left the bypass network.
// ---------------------------------------------------------------------------
module tb_alu_issue_scoreboard;

    typedef struct packed {
        logic       dv;
        logic [4:0] ra;
        logic [4:0] rb;
        logic [4:0] rd;
        logic       ura;
        logic       urb;
        logic       wrd;
        logic       mul;
        logic       ld;
        logic       stall;
        logic       flush;
        logic       mdv;
        logic [4:0] mdr;
        logic       wbv;
        logic [4:0] wbr;
    } stim_t;

    logic        clock;
    logic        reset;
    stim_t       s;
    stim_t       cur;
    logic        issue_valid;
    logic        dec_stall;
    logic [1:0]  ra_bp_sel;
    logic [1:0]  rb_bp_sel;
    logic [31:0] sb_pending;

    int total;
    int bad;

    // behavioural model
    bit m_busy [32];
    bit m_ld   [32];
    bit m_done [32];
    int m_left [32];

    logic        exp_iv;
    logic        exp_ds;
    logic [1:0]  exp_sa;
    logic [1:0]  exp_sb;
    logic [31:0] exp_pend;

    alu_issue_scoreboard dut (
        .clock          (clock),
        .reset          (reset),
        .dec_valid      (cur.dv),
        .dec_ra_addr    (cur.ra),
        .dec_rb_addr    (cur.rb),
        .dec_rd_addr    (cur.rd),
        .dec_uses_ra    (cur.ura),
        .dec_uses_rb    (cur.urb),
        .dec_writes_rd  (cur.wrd),
        .dec_is_mul     (cur.mul),
        .dec_is_load    (cur.ld),
        .stall_alu      (cur.stall),
        .flush          (cur.flush),
        .mem_done_valid (cur.mdv),
        .mem_done_rd    (cur.mdr),
        .wb_valid       (cur.wbv),
        .wb_rd          (cur.wbr),
        .issue_valid    (issue_valid),
        .dec_stall      (dec_stall),
        .ra_bp_sel      (ra_bp_sel),
        .rb_bp_sel      (rb_bp_sel),
        .sb_pending     (sb_pending)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void model_clear();
        for (int i = 0; i < 32; i++) begin
            m_busy[i] = 1'b0;
            m_ld[i]   = 1'b0;
            m_done[i] = 1'b0;
            m_left[i] = 0;
        end
    endfunction

    function automatic void src_eval(input logic u, input logic [4:0] r,
                                     output logic rdy, output logic [1:0] sel);
        rdy = 1'b1;
        sel = 2'b00;
        if (u && r != 5'd0 && m_busy[r]) begin
            if (cur.wbv && cur.wbr == r) begin
                sel = 2'b00;
            end else if (m_ld[r] && !m_done[r] && cur.mdv && cur.mdr == r) begin
                sel = 2'b10;
            end else if (!m_ld[r] && !m_done[r] && m_left[r] == 0) begin
                sel = 2'b01;
            end else begin
                rdy = 1'b0;
            end
        end
    endfunction

    function automatic void model_eval();
        logic ok_a, ok_b, dhaz, haz;
        src_eval(cur.ura, cur.ra, ok_a, exp_sa);
        src_eval(cur.urb, cur.rb, ok_b, exp_sb);
        dhaz   = cur.wrd && cur.rd != 5'd0 && m_busy[cur.rd] && !(cur.wbv && cur.wbr == cur.rd);
        haz    = !ok_a || !ok_b || dhaz;
        exp_iv = cur.dv && !haz && !cur.stall && !cur.flush;
        exp_ds = cur.dv && !cur.flush && (haz || cur.stall);
        for (int i = 0; i < 32; i++) exp_pend[i] = m_busy[i];
    endfunction

    function automatic void model_commit();
        for (int r = 1; r < 32; r++) begin
            if (exp_iv && cur.wrd && cur.rd == 5'(r)) begin
                m_busy[r] = 1'b1;
                m_ld[r]   = cur.ld;
                m_done[r] = 1'b0;
                m_left[r] = cur.mul ? 5 : 1;
            end else if (m_busy[r]) begin
                if (cur.wbv && cur.wbr == 5'(r)) begin
                    m_busy[r] = 1'b0;
                end else if (!m_done[r]) begin
                    if (m_ld[r]) begin
                        if (cur.mdv && cur.mdr == 5'(r)) m_done[r] = 1'b1;
                    end else if (!cur.stall) begin
                        if (m_left[r] == 0) m_done[r] = 1'b1;
                        else m_left[r] = m_left[r] - 1;
                    end
                end
            end
        end
    endfunction

    // Apply staged stimulus at the falling edge, sample 1 time unit later.
    task automatic step();
        @(negedge clock);
        cur = s;
        #1;
        model_eval();
        model_commit();
    endtask

    function automatic void idle_s();
        s = '0;
    endfunction

    function automatic void set_op(input int rd, input int ra, input int rb,
                                   input logic ura, input logic urb, input logic wrd,
                                   input logic mul, input logic ld);
        s.dv  = 1'b1;
        s.rd  = 5'(rd);
        s.ra  = 5'(ra);
        s.rb  = 5'(rb);
        s.ura = ura;
        s.urb = urb;
        s.wrd = wrd;
        s.mul = mul;
        s.ld  = ld;
    endfunction

    task automatic drain();
        for (int r = 1; r < 32; r++) begin
            if (m_busy[r]) begin
                idle_s();
                s.wbv = 1'b1;
                s.wbr = 5'(r);
                step();
            end
        end
        idle_s();
        step();
        total++;
        if (sb_pending !== 32'h0) begin
            bad++;
            $display("FAIL drain_pending got=%h want=%h", sb_pending, 32'h0);
        end
    endtask

    task automatic test_reset();
        model_clear();
        idle_s();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            total++;
            if (sb_pending !== 32'h0) begin
                bad++;
                $display("FAIL reset_pending got=%h want=%h", sb_pending, 32'h0);
            end
            total++;
            if ({issue_valid, dec_stall, ra_bp_sel, rb_bp_sel} !== 6'b0) begin
                bad++;
                $display("FAIL reset_outputs got=%b want=%b",
                         {issue_valid, dec_stall, ra_bp_sel, rb_bp_sel}, 6'b0);
            end
        end
        reset = 1'b1;
    endtask

    task automatic test_alu_bypass();
        idle_s();
        set_op(1, 10, 11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        total++;
        if (issue_valid !== 1'b1 || dec_stall !== 1'b0) begin
            bad++;
            $display("FAIL add_issue got=%b%b want=10", issue_valid, dec_stall);
        end
        idle_s();
        set_op(2, 1, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        total++;
        if (dec_stall !== 1'b1 || issue_valid !== 1'b0 || sb_pending[1] !== 1'b1) begin
            bad++;
            $display("FAIL raw_exec_stall got=%b%b%b want=101", dec_stall, issue_valid, sb_pending[1]);
        end
        step();
        total++;
        if (issue_valid !== 1'b1 || ra_bp_sel !== 2'b01) begin
            bad++;
            $display("FAIL raw_alu_bypass got=%b/%b want=1/01", issue_valid, ra_bp_sel);
        end
        drain();
    endtask

    task automatic test_mul();
        int  n;
        bit  done;
        idle_s();
        set_op(3, 12, 13, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        step();
        total++;
        if (issue_valid !== 1'b1) begin
            bad++;
            $display("FAIL mul_issue got=%b want=1", issue_valid);
        end
        idle_s();
        set_op(4, 3, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        n = 0;
        done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            step();
            if (issue_valid === 1'b1) begin
                done = 1'b1;
                total++;
                if (ra_bp_sel !== 2'b01) begin
                    bad++;
                    $display("FAIL mul_dep_sel got=%b want=01", ra_bp_sel);
                end
            end else if (dec_stall === 1'b1) begin
                n++;
            end
        end
        total++;
        if (!done || n != 5) begin
            bad++;
            $display("FAIL mul_stall_cycles got=%0d issued=%0d want=5 issued=1", n, done);
        end
        drain();
    endtask

    task automatic test_load();
        idle_s();
        set_op(5, 14, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        step();
        total++;
        if (issue_valid !== 1'b1) begin
            bad++;
            $display("FAIL ld_issue got=%b want=1", issue_valid);
        end
        idle_s();
        set_op(6, 5, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step();
            total++;
            if (dec_stall !== 1'b1 || issue_valid !== 1'b0) begin
                bad++;
                $display("FAIL ld_wait_stall got=%b%b want=10", dec_stall, issue_valid);
            end
        end
        s.mdv = 1'b1;
        s.mdr = 5'd5;
        step();
        total++;
        if (issue_valid !== 1'b1 || ra_bp_sel !== 2'b10) begin
            bad++;
            $display("FAIL ld_cache_bypass got=%b/%b want=1/10", issue_valid, ra_bp_sel);
        end
        idle_s();
        set_op(7, 0, 5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            step();
            total++;
            if (dec_stall !== 1'b1) begin
                bad++;
                $display("FAIL ld_wb_wait got=%b want=1", dec_stall);
            end
        end
        s.wbv = 1'b1;
        s.wbr = 5'd5;
        step();
        total++;
        if (issue_valid !== 1'b1 || rb_bp_sel !== 2'b00) begin
            bad++;
            $display("FAIL ld_wb_through got=%b/%b want=1/00", issue_valid, rb_bp_sel);
        end
        drain();
    endtask

    task automatic test_hazards();
        int n;
        bit done;
        idle_s();
        set_op(7, 20, 21, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        idle_s();
        step();
        step();
        set_op(7, 22, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            step();
            total++;
            if (dec_stall !== 1'b1 || issue_valid !== 1'b0) begin
                bad++;
                $display("FAIL waw_stall got=%b%b want=10", dec_stall, issue_valid);
            end
        end
        s.wbv = 1'b1;
        s.wbr = 5'd7;
        step();
        total++;
        if (issue_valid !== 1'b1) begin
            bad++;
            $display("FAIL waw_release got=%b want=1", issue_valid);
        end
        idle_s();
        step();
        total++;
        if (sb_pending[7] !== 1'b1) begin
            bad++;
            $display("FAIL issue_beats_wb got=%b want=1", sb_pending[7]);
        end
        drain();

        idle_s();
        set_op(3, 12, 13, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        step();
        idle_s();
        set_op(4, 3, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        n = 0;
        done = 1'b0;
        for (int k = 0; k < 30 && !done; k++) begin
            s.stall = (k < 3);
            step();
            if (issue_valid === 1'b1) done = 1'b1;
            else if (dec_stall === 1'b1) n++;
        end
        total++;
        if (!done || n != 8) begin
            bad++;
            $display("FAIL mul_stall_freeze got=%0d issued=%0d want=8 issued=1", n, done);
        end
        drain();
    endtask

    task automatic test_corner();
        idle_s();
        set_op(0, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        total++;
        if (issue_valid !== 1'b1 || dec_stall !== 1'b0 || ra_bp_sel !== 2'b00) begin
            bad++;
            $display("FAIL r0_issue got=%b%b%b want=1000", issue_valid, dec_stall, ra_bp_sel);
        end
        idle_s();
        step();
        total++;
        if (sb_pending !== 32'h0) begin
            bad++;
            $display("FAIL r0_untracked got=%h want=%h", sb_pending, 32'h0);
        end
        set_op(9, 23, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        s.flush = 1'b1;
        step();
        total++;
        if (issue_valid !== 1'b0 || dec_stall !== 1'b0) begin
            bad++;
            $display("FAIL flush_kill got=%b%b want=00", issue_valid, dec_stall);
        end
        idle_s();
        s.mdv = 1'b1;
        s.mdr = 5'd9;
        s.wbv = 1'b1;
        s.wbr = 5'd8;
        step();
        idle_s();
        step();
        total++;
        if (sb_pending !== 32'h0) begin
            bad++;
            $display("FAIL free_ignores_done got=%h want=%h", sb_pending, 32'h0);
        end
    endtask

    task automatic test_reset_mid();
        idle_s();
        set_op(3, 12, 13, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        step();
        idle_s();
        set_op(5, 14, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        step();
        idle_s();
        step();
        total++;
        if (sb_pending !== 32'h0000_0028) begin
            bad++;
            $display("FAIL mid_setup got=%h want=%h", sb_pending, 32'h0000_0028);
        end
        reset = 1'b0;
        #1;
        total++;
        if (sb_pending !== 32'h0) begin
            bad++;
            $display("FAIL mid_async_clear got=%h want=%h", sb_pending, 32'h0);
        end
        model_clear();
        step();
        reset = 1'b1;
        set_op(4, 3, 5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        total++;
        if (issue_valid !== 1'b1 || dec_stall !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_issue got=%b%b want=10", issue_valid, dec_stall);
        end
        drain();
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            idle_s();
            s.dv    = ($urandom_range(0, 3) != 0);
            s.ra    = 5'($urandom_range(0, 7));
            s.rb    = 5'($urandom_range(0, 7));
            s.rd    = 5'($urandom_range(0, 7));
            s.ura   = 1'($urandom_range(0, 1));
            s.urb   = 1'($urandom_range(0, 1));
            s.wrd   = ($urandom_range(0, 3) != 0);
            s.mul   = ($urandom_range(0, 3) == 0);
            s.ld    = !s.mul && ($urandom_range(0, 3) == 0);
            s.stall = ($urandom_range(0, 7) == 0);
            s.flush = ($urandom_range(0, 15) == 0);
            s.mdv   = ($urandom_range(0, 2) == 0);
            s.mdr   = 5'($urandom_range(0, 7));
            s.wbv   = ($urandom_range(0, 3) == 0);
            s.wbr   = 5'($urandom_range(0, 7));
            step();
            total++;
            if (issue_valid !== exp_iv) begin
                bad++;
                $display("FAIL rnd_issue cyc=%0d got=%b want=%b", k, issue_valid, exp_iv);
            end
            total++;
            if (dec_stall !== exp_ds) begin
                bad++;
                $display("FAIL rnd_stall cyc=%0d got=%b want=%b", k, dec_stall, exp_ds);
            end
            total++;
            if (ra_bp_sel !== exp_sa) begin
                bad++;
                $display("FAIL rnd_ra_sel cyc=%0d got=%b want=%b", k, ra_bp_sel, exp_sa);
            end
            total++;
            if (rb_bp_sel !== exp_sb) begin
                bad++;
                $display("FAIL rnd_rb_sel cyc=%0d got=%b want=%b", k, rb_bp_sel, exp_sb);
            end
            total++;
            if (sb_pending !== exp_pend) begin
                bad++;
                $display("FAIL rnd_pending cyc=%0d got=%h want=%h", k, sb_pending, exp_pend);
            end
        end
        drain();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        s     = '0;
        cur   = '0;
        reset = 1'b0;
        test_reset();
        test_alu_bypass();
        test_mul();
        test_load();
        test_hazards();
        test_corner();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
